// File: rtl/hub75_panel_rx.sv
// HUB75 panel-side sink: samples the driver pins, rebuilds each shifted row and replays it as a valid/ready pixel stream.
// Optional per-row nOE-low cycle statistics are enabled by defining HUB75_RX_OE_STATS_EN.
module hub75_panel_rx #(
    parameter  int unsigned WIDTH    = 64,
    parameter  int unsigned OE_CNT_W = 16,
    localparam int unsigned COL_W    = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                A,
    input  logic                B,
    input  logic                C,
    input  logic                D,
    input  logic                E,
    input  logic                R0,
    input  logic                G0,
    input  logic                B0,
    input  logic                R1,
    input  logic                G1,
    input  logic                B1,
    input  logic                S_CLK,
    input  logic                LATCH,
    input  logic                nOE,
    output logic                px_valid,
    input  logic                px_ready,
    output logic [4:0]          px_row,
    output logic [COL_W-1:0]    px_col,
    output logic [2:0]          px_top,
    output logic [2:0]          px_bot,
    output logic                px_last,
    output logic [OE_CNT_W-1:0] px_oe_cycles,
    output logic                overrun,
    output logic                len_err
);

    localparam int unsigned PIX_W  = 6;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned SYNC_W = ROW_W + PIX_W + 2;
    localparam int unsigned CNT_W  = $clog2(WIDTH + 2);
    localparam int unsigned SR_W   = WIDTH * PIX_W;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state;
    logic [SYNC_W-1:0] pins, sync1, sync2;
    logic              sclk_prev, latch_prev;
    logic              sclk_edge, latch_edge, beat, last_beat, load;
    logic [SR_W-1:0]   sr, sr_next, row_buf;
    logic [CNT_W-1:0]  edge_cnt, edge_cnt_next;

    // Address and pixel bits share the strobe delay so data lines up with its S_CLK edge
    assign pins = {E, D, C, B, A, R0, G0, B0, R1, G1, B1, S_CLK, LATCH};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1      <= '0;
            sync2      <= '0;
            sclk_prev  <= 1'b0;
            latch_prev <= 1'b0;
        end else begin
            sync1      <= pins;
            sync2      <= sync1;
            sclk_prev  <= sync2[1];
            latch_prev <= sync2[0];
        end
    end

    assign sclk_edge  = sync2[1] & ~sclk_prev;
    assign latch_edge = sync2[0] & ~latch_prev;

    // A shift coinciding with a latch lands in the latched row
    assign sr_next       = sclk_edge ? {sr[SR_W-PIX_W-1:0], sync2[2 +: PIX_W]} : sr;
    assign edge_cnt_next = (sclk_edge && edge_cnt != CNT_W'(WIDTH + 1)) ? edge_cnt + CNT_W'(1) : edge_cnt;

    assign beat      = px_valid & px_ready;
    assign last_beat = beat & px_last;
    assign load      = latch_edge & ((state == IDLE) | last_beat);

    // Row buffer drains from the bottom entry, so the current column is always entry 0
    assign px_top = row_buf[5:3];
    assign px_bot = row_buf[2:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            sr       <= '0;
            row_buf  <= '0;
            edge_cnt <= '0;
            px_valid <= 1'b0;
            px_row   <= '0;
            px_col   <= '0;
            px_last  <= 1'b0;
            overrun  <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            sr       <= sr_next;
            edge_cnt <= latch_edge ? '0 : edge_cnt_next;
            if (latch_edge && edge_cnt_next != CNT_W'(WIDTH))
                len_err <= 1'b1;
            if (latch_edge && state == EMIT && !last_beat)
                overrun <= 1'b1;

            if (load) begin
                state    <= EMIT;
                px_valid <= 1'b1;
                row_buf  <= sr_next;
                px_row   <= sync2[SYNC_W-1 -: ROW_W];
                px_col   <= '0;
                px_last  <= 1'b0;
            end else if (beat) begin
                if (px_last) begin
                    state    <= IDLE;
                    px_valid <= 1'b0;
                    px_col   <= '0;
                    px_last  <= 1'b0;
                end else begin
                    row_buf  <= row_buf >> PIX_W;
                    px_col   <= px_col + COL_W'(1);
                    px_last  <= (px_col == COL_W'(WIDTH - 2));
                end
            end
        end
    end

`ifdef HUB75_RX_OE_STATS_EN
    logic                noe_s1, noe_s2;
    logic [OE_CNT_W-1:0] oe_cnt;

    // nOE-low cycles between latches; the accepted row carries the count of its latch interval
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            noe_s1       <= 1'b0;
            noe_s2       <= 1'b0;
            oe_cnt       <= '0;
            px_oe_cycles <= '0;
        end else begin
            noe_s1 <= nOE;
            noe_s2 <= noe_s1;
            if (latch_edge)
                oe_cnt <= '0;
            else if (!noe_s2 && oe_cnt != {OE_CNT_W{1'b1}})
                oe_cnt <= oe_cnt + OE_CNT_W'(1);
            if (load)
                px_oe_cycles <= oe_cnt;
        end
    end
`else
    logic unused_noe;
    assign unused_noe   = nOE;
    assign px_oe_cycles = '0;
`endif

endmodule
